// File: rtl/wb_stage.sv
// wb_stage: LemonPC writeback stage.
// Retires ops from execute, waits for load data, aligns and extends it,
// and drives the register file write port one cycle after the result is known.
// Also flags load-use hazards toward decode and counts retired ops.
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic [2:0]            ex_funct3,
  input  logic [1:0]            ex_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [ADDR_WIDTH-1:0] hz_rs1,
  input  logic [ADDR_WIDTH-1:0] hz_rs2,
  output logic                  hz_stall,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  output logic [63:0]           instret,
  output logic                  err
);

  // The wait timer counts empty WAIT_LOAD cycles 0..TIMEOUT-1; the abort
  // fires on the edge that would otherwise complete the TIMEOUT-th empty cycle.
  localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [ADDR_WIDTH-1:0] RD_ZERO = {ADDR_WIDTH{1'b0}};

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   pending_rd_r;
  logic [2:0]              funct3_r;
  logic [1:0]              addr_lo_r;
  logic [TIMER_W-1:0]      timer_r;
  logic                    rf_wen_r;
  logic [ADDR_WIDTH-1:0]   rf_rd_r;
  logic [DATA_WIDTH-1:0]   rf_data_r;
  logic [63:0]             instret_r;
  logic                    err_r;

  logic                    accept_s;
  logic                    idle_s;
  logic                    hz_match_s;
  logic [DATA_WIDTH-1:0]   load_data_s;

  // A load is unusable if its size/alignment combination is illegal or
  // the funct3 encoding is not one of the five defined load kinds.
  function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] lo);
    logic fault;
    case (f3)
      F3_LB, F3_LBU: fault = 1'b0;
      F3_LH, F3_LHU: fault = lo[0];
      F3_LW:         fault = (lo != 2'b00);
      default:       fault = 1'b1;
    endcase
    return fault;
  endfunction

  // Picks the addressed byte/half out of the aligned word and extends it.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word,
    input logic [2:0]            f3,
    input logic [1:0]            lo
  );
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_WIDTH-1:0] res;
    case (lo)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   res = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      F3_LH:   res = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      F3_LBU:  res = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      F3_LHU:  res = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // Handshake, hazard detection and load data alignment are pure decode of current state.
  always_comb begin
    idle_s      = (state_r == IDLE);
    accept_s    = ex_valid & idle_s;
    hz_match_s  = (hz_rs1 == pending_rd_r) | (hz_rs2 == pending_rd_r);
    hz_stall    = (state_r == WAIT_LOAD) & (pending_rd_r != RD_ZERO) & hz_match_s;
    load_data_s = load_extract(mem_rdata, funct3_r, addr_lo_r);
  end

  assign ex_ready = idle_s;
  assign rf_wen   = rf_wen_r;
  assign rf_rd    = rf_rd_r;
  assign rf_dataD = rf_data_r;
  assign instret  = instret_r;
  assign err      = err_r;

  // Writeback FSM: accepts ops, tracks the outstanding load and registers every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pending_rd_r <= RD_ZERO;
      funct3_r     <= 3'b000;
      addr_lo_r    <= 2'b00;
      timer_r      <= {TIMER_W{1'b0}};
      rf_wen_r     <= 1'b0;
      rf_rd_r      <= RD_ZERO;
      rf_data_r    <= {DATA_WIDTH{1'b0}};
      instret_r    <= 64'd0;
      err_r        <= 1'b0;
    end else begin
      // rf_wen is a single-cycle pulse unless a write is issued below
      rf_wen_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (!ex_is_load) begin
              rf_wen_r  <= ex_wen & (ex_rd != RD_ZERO);
              rf_rd_r   <= ex_rd;
              rf_data_r <= ex_result;
              instret_r <= instret_r + 64'd1;
            end else if (load_fault(ex_funct3, ex_addr_lo)) begin
              // unusable load retires immediately without touching the register file
              err_r     <= 1'b1;
              instret_r <= instret_r + 64'd1;
            end else begin
              pending_rd_r <= ex_wen ? ex_rd : RD_ZERO;
              funct3_r     <= ex_funct3;
              addr_lo_r    <= ex_addr_lo;
              timer_r      <= {TIMER_W{1'b0}};
              state_r      <= WAIT_LOAD;
            end
          end
        end
        WAIT_LOAD: begin
          if (mem_rvalid) begin
            // data arriving on the last allowed cycle still completes the load
            rf_wen_r     <= (pending_rd_r != RD_ZERO);
            rf_rd_r      <= pending_rd_r;
            rf_data_r    <= load_data_s;
            instret_r    <= instret_r + 64'd1;
            pending_rd_r <= RD_ZERO;
            state_r      <= IDLE;
          end else if (timer_r == TIMER_LAST) begin
            err_r        <= 1'b1;
            pending_rd_r <= RD_ZERO;
            state_r      <= IDLE;
          end else begin
            timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
